// File: rtl/imem_dmem_loader_if.sv
// Loader bus: host-side start/length/byte stream in, data-memory init port and status out.
interface imem_dmem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   length;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              init_write_enable;
  logic [ADDR_W-1:0] init_addr;
  logic [31:0]       init_data;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;

  // Host side: requests a load and streams bytes, observes the init port and status.
  modport master (
    output start, length, byte_valid, byte_data,
    input  byte_ready, init_write_enable, init_addr, init_data,
    input  core_reset, busy, done, checksum
  );

  // Loader side.
  modport slave (
    input  start, length, byte_valid, byte_data,
    output byte_ready, init_write_enable, init_addr, init_data,
    output core_reset, busy, done, checksum
  );
endinterface

// File: rtl/imem_dmem_loader.sv
// Boot loader: packs a byte stream into 32-bit words, writes them to consecutive
// data-memory init addresses, keeps a running checksum and holds the core in reset
// until the image is complete.
module imem_dmem_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  imem_dmem_loader_if.slave   bus
);

  // Word index and length need one extra bit so a full 2^ADDR_W image is representable.
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loaderState_t;

  loaderState_t      state, stateNext;
  logic [31:0]       word, wordNext;
  logic [1:0]        byteCount, byteCountNext;
  logic [LEN_W-1:0]  wordIndex, wordIndexNext;
  logic [LEN_W-1:0]  lengthReg, lengthRegNext;
  logic [31:0]       checksumQ, checksumNext;
  logic [ADDR_W-1:0] initAddrQ, initAddrNext;
  logic [31:0]       initDataQ, initDataNext;
  logic              initWeQ, initWeNext;
  logic              byteReadyQ, busyQ, doneQ, coreResetQ;
  logic              accept;

  // Next-state and next-register values; status outputs are decoded from the next state
  // so that they are registered yet line up with the state they describe.
  always_comb begin
    stateNext     = state;
    wordNext      = word;
    byteCountNext = byteCount;
    wordIndexNext = wordIndex;
    lengthRegNext = lengthReg;
    checksumNext  = checksumQ;
    initAddrNext  = initAddrQ;
    initDataNext  = initDataQ;
    initWeNext    = 1'b0;
    accept        = byteReadyQ && bus.byte_valid;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          lengthRegNext = bus.length;
          checksumNext  = 32'd0;
          wordIndexNext = '0;
          byteCountNext = 2'd0;
          stateNext     = (bus.length == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (accept) begin
          wordNext = BIG_ENDIAN ? {word[23:0], bus.byte_data}
                                : {bus.byte_data, word[31:8]};
          if (byteCount == 2'd3) begin
            byteCountNext = 2'd0;
            stateNext     = WRITE;
            initWeNext    = 1'b1;
            initAddrNext  = wordIndex[ADDR_W-1:0];
            initDataNext  = wordNext;
          end else begin
            byteCountNext = byteCount + 2'd1;
          end
        end
      end
      WRITE: begin
        checksumNext = checksumQ + word;
        if ((wordIndex + LEN_W'(1)) == lengthReg) begin
          stateNext = DONE;
        end else begin
          wordIndexNext = wordIndex + LEN_W'(1);
          stateNext     = RECV;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word       <= 32'd0;
      byteCount  <= 2'd0;
      wordIndex  <= '0;
      lengthReg  <= '0;
      checksumQ  <= 32'd0;
      initAddrQ  <= '0;
      initDataQ  <= 32'd0;
      initWeQ    <= 1'b0;
      byteReadyQ <= 1'b0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
      coreResetQ <= 1'b1;
    end else begin
      state      <= stateNext;
      word       <= wordNext;
      byteCount  <= byteCountNext;
      wordIndex  <= wordIndexNext;
      lengthReg  <= lengthRegNext;
      checksumQ  <= checksumNext;
      initAddrQ  <= initAddrNext;
      initDataQ  <= initDataNext;
      initWeQ    <= initWeNext;
      byteReadyQ <= (stateNext == RECV);
      busyQ      <= (stateNext == RECV) || (stateNext == WRITE);
      doneQ      <= (stateNext == DONE);
      coreResetQ <= (stateNext != DONE);
    end
  end

  assign bus.byte_ready        = byteReadyQ;
  assign bus.init_write_enable = initWeQ;
  assign bus.init_addr         = initAddrQ;
  assign bus.init_data         = initDataQ;
  assign bus.core_reset        = coreResetQ;
  assign bus.busy              = busyQ;
  assign bus.done              = doneQ;
  assign bus.checksum          = checksumQ;

endmodule

// File: tb/tb_imem_dmem_loader.sv
// Directed bench: big- and little-endian loaders driven by one shared byte stream.
module tb_imem_dmem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LOG_N  = 512;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   length;
  logic              byteValid;
  logic [7:0]        byteData;

  int errors = 0;
  int checks = 0;

  imem_dmem_loader_if #(.ADDR_W(ADDR_W)) busBe ();
  imem_dmem_loader_if #(.ADDR_W(ADDR_W)) busLe ();

  assign busBe.start      = start;
  assign busBe.length     = length;
  assign busBe.byte_valid = byteValid;
  assign busBe.byte_data  = byteData;
  assign busLe.start      = start;
  assign busLe.length     = length;
  assign busLe.byte_valid = byteValid;
  assign busLe.byte_data  = byteData;

  imem_dmem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dutBe (
    .clk(clk), .reset(reset), .bus(busBe)
  );
  imem_dmem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b0)) dutLe (
    .clk(clk), .reset(reset), .bus(busLe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for latency measurements.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write logs and protocol-violation counters, sampled on the falling edge.
  logic [ADDR_W-1:0] logAddrBe [LOG_N];
  logic [31:0]       logDataBe [LOG_N];
  logic [ADDR_W-1:0] logAddrLe [LOG_N];
  logic [31:0]       logDataLe [LOG_N];
  int wcBe = 0;
  int wcLe = 0;
  int accCnt = 0;
  int fourthCyc = -10;
  int badTiming = 0;
  int badCore = 0;

  always @(negedge clk) begin
    if (reset) begin
      accCnt <= 0;
    end else if (busBe.byte_valid && busBe.byte_ready) begin
      if (accCnt == 3) begin
        accCnt    <= 0;
        fourthCyc <= cyc;
      end else begin
        accCnt <= accCnt + 1;
      end
    end
    if (busBe.init_write_enable) begin
      logAddrBe[wcBe] <= busBe.init_addr;
      logDataBe[wcBe] <= busBe.init_data;
      wcBe <= wcBe + 1;
      if (cyc != fourthCyc + 1 || busBe.byte_ready) badTiming <= badTiming + 1;
    end
    if (busLe.init_write_enable) begin
      logAddrLe[wcLe] <= busLe.init_addr;
      logDataLe[wcLe] <= busLe.init_data;
      wcLe <= wcLe + 1;
      if (busLe.byte_ready) badTiming <= badTiming + 1;
    end
    if ((busBe.busy && !busBe.core_reset) || (busBe.done && busBe.core_reset) ||
        (busLe.busy && !busLe.core_reset) || (busLe.done && busLe.core_reset))
      badCore <= badCore + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart(input int len);
    start  = 1'b1;
    length = (ADDR_W+1)'(len);
    tick();
    start  = 1'b0;
  endtask

  // Present one byte and hold it until the loader takes it.
  task automatic sendByte(input logic [7:0] b, input bit gaps, input bit toggle);
    bit hs;
    int n;
    hs = 1'b0;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        byteValid = 1'b0;
        byteData  = 8'($urandom);
        if (toggle) start = 1'($urandom_range(0, 1));
        tick();
      end
    end
    byteValid = 1'b1;
    byteData  = b;
    for (int t = 0; t < 20 && !hs; t++) begin
      if (toggle) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      hs = busBe.byte_ready;
      tick();
    end
    byteValid = 1'b0;
    start     = 1'b0;
    if (!hs) chk("byte_accept_timeout", 64'(hs), 64'd1);
  endtask

  task automatic waitDone(input int maxCyc);
    int n;
    n = 0;
    while (!busBe.done && n < maxCyc) begin
      tick();
      n++;
    end
    chk("done_reached", 64'(busBe.done), 64'd1);
  endtask

  task automatic chkWrite(input string tag, input int idx, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] beData, input logic [31:0] leData);
    chk({tag, "_addr_be"}, 64'(logAddrBe[idx]), 64'(addr));
    chk({tag, "_data_be"}, 64'(logDataBe[idx]), 64'(beData));
    chk({tag, "_addr_le"}, 64'(logAddrLe[idx]), 64'(addr));
    chk({tag, "_data_le"}, 64'(logDataLe[idx]), 64'(leData));
  endtask

  task automatic chkResetValues(input string tag);
    chk({tag, "_byte_ready"}, 64'(busBe.byte_ready), 64'd0);
    chk({tag, "_we"},         64'(busBe.init_write_enable), 64'd0);
    chk({tag, "_addr"},       64'(busBe.init_addr), 64'd0);
    chk({tag, "_data"},       64'(busBe.init_data), 64'd0);
    chk({tag, "_core_reset"}, 64'(busBe.core_reset), 64'd1);
    chk({tag, "_busy"},       64'(busBe.busy), 64'd0);
    chk({tag, "_done"},       64'(busBe.done), 64'd0);
    chk({tag, "_checksum"},   64'(busBe.checksum), 64'd0);
  endtask

  function automatic logic [31:0] genBe(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {a, ~a, 8'h5A, a ^ 8'hC3};
  endfunction

  function automatic logic [31:0] genLe(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {a ^ 8'hC3, 8'h5A, ~a, a};
  endfunction

  logic [7:0]  stream [8];
  logic [7:0]  bw [4];
  logic [31:0] sumBe, sumLe, w;
  int base, cycStart;

  initial begin
    stream[0] = 8'h12; stream[1] = 8'h34; stream[2] = 8'h56; stream[3] = 8'h78;
    stream[4] = 8'h9A; stream[5] = 8'hBC; stream[6] = 8'hDE; stream[7] = 8'hF0;
    reset = 1'b1; start = 1'b0; length = '0; byteValid = 1'b0; byteData = 8'h00;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state, then idle with stray valid bytes that must not be taken.
    chkResetValues("reset");
    byteValid = 1'b1; byteData = 8'hEE;
    repeat (10) tick();
    byteValid = 1'b0;
    chk("idle_writes", 64'(wcBe), 64'd0);
    chk("idle_core_reset", 64'(busBe.core_reset), 64'd1);
    chk("idle_done", 64'(busBe.done), 64'd0);
    chk("idle_byte_ready", 64'(busBe.byte_ready), 64'd0);

    // Two-word load, valid held high: peak throughput.
    doStart(2);
    cycStart = cyc;
    chk("load1_busy", 64'(busBe.busy), 64'd1);
    chk("load1_core_reset", 64'(busBe.core_reset), 64'd1);
    for (int i = 0; i < 8; i++) sendByte(stream[i], 1'b0, 1'b0);
    waitDone(20);
    chk("load1_latency", 64'(cyc - cycStart), 64'd10);
    chk("load1_writes", 64'(wcBe), 64'd2);
    chkWrite("load1_w0", 0, 8'd0, 32'h12345678, 32'h78563412);
    chkWrite("load1_w1", 1, 8'd1, 32'h9ABCDEF0, 32'hF0DEBC9A);
    chk("load1_checksum_be", 64'(busBe.checksum), 64'hACF13568);
    chk("load1_checksum_le", 64'(busLe.checksum), 64'h6934F0AC);
    chk("load1_core_reset_after", 64'(busBe.core_reset), 64'd0);
    chk("load1_busy_after", 64'(busBe.busy), 64'd0);

    // Same stream from DONE with gapped valid and start toggling mid-load.
    doStart(2);
    chk("load2_core_reset", 64'(busBe.core_reset), 64'd1);
    chk("load2_checksum_cleared", 64'(busBe.checksum), 64'd0);
    for (int i = 0; i < 8; i++) sendByte(stream[i], 1'b1, 1'b1);
    waitDone(20);
    chk("load2_writes", 64'(wcBe), 64'd4);
    chkWrite("load2_w0", 2, 8'd0, 32'h12345678, 32'h78563412);
    chkWrite("load2_w1", 3, 8'd1, 32'h9ABCDEF0, 32'hF0DEBC9A);
    chk("load2_checksum_be", 64'(busBe.checksum), 64'hACF13568);
    chk("load2_checksum_le", 64'(busLe.checksum), 64'h6934F0AC);

    // Zero-length load completes immediately with no writes.
    doStart(0);
    chk("len0_done", 64'(busBe.done), 64'd1);
    chk("len0_checksum", 64'(busBe.checksum), 64'd0);
    repeat (3) tick();
    chk("len0_writes", 64'(wcBe), 64'd4);
    chk("len0_core_reset", 64'(busBe.core_reset), 64'd0);

    // Reset after five bytes of a three-word load.
    doStart(3);
    sendByte(8'h11, 1'b0, 1'b0); sendByte(8'h22, 1'b0, 1'b0);
    sendByte(8'h33, 1'b0, 1'b0); sendByte(8'h44, 1'b0, 1'b0);
    sendByte(8'h55, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chkResetValues("abort");
    reset = 1'b0;
    tick();
    chk("abort_writes", 64'(wcBe), 64'd5);
    chkWrite("abort_w0", 4, 8'd0, 32'h11223344, 32'h44332211);

    // Fresh load after the abort starts again at address 0.
    doStart(1);
    sendByte(8'hA1, 1'b0, 1'b0); sendByte(8'hB2, 1'b0, 1'b0);
    sendByte(8'hC3, 1'b0, 1'b0); sendByte(8'hD4, 1'b0, 1'b0);
    waitDone(10);
    chkWrite("reload_w0", 5, 8'd0, 32'hA1B2C3D4, 32'hD4C3B2A1);
    chk("reload_checksum_be", 64'(busBe.checksum), 64'hA1B2C3D4);
    chk("reload_checksum_le", 64'(busLe.checksum), 64'hD4C3B2A1);

    // Full-size image from DONE: every address written exactly once.
    base = wcBe;
    sumBe = 32'd0;
    sumLe = 32'd0;
    doStart(256);
    chk("full_core_reset", 64'(busBe.core_reset), 64'd1);
    for (int i = 0; i < 256; i++) begin
      w = genBe(i);
      bw[0] = w[31:24]; bw[1] = w[23:16]; bw[2] = w[15:8]; bw[3] = w[7:0];
      for (int k = 0; k < 4; k++) sendByte(bw[k], 1'b0, 1'b0);
      sumBe = sumBe + genBe(i);
      sumLe = sumLe + genLe(i);
    end
    waitDone(10);
    chk("full_writes", 64'(wcBe - base), 64'd256);
    for (int i = 0; i < 256; i++)
      chkWrite($sformatf("full_w%0d", i), base + i, 8'(i), genBe(i), genLe(i));
    chk("full_checksum_be", 64'(busBe.checksum), 64'(sumBe));
    chk("full_checksum_le", 64'(busLe.checksum), 64'(sumLe));
    chk("full_core_reset_after", 64'(busBe.core_reset), 64'd0);

    tick();
    chk("strobe_timing", 64'(badTiming), 64'd0);
    chk("core_reset_consistency", 64'(badCore), 64'd0);
    chk("le_write_count", 64'(wcLe), 64'(wcBe));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
